// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the two-client multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_CLIENTS     = 2;
    localparam int DEF_WDOG_CYCLES = 8;

endpackage : mult_arb_pkg

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick. The last-grant history
// register lives in the caller; this block only decides the winner.
module rr_arb2
    import mult_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic                   i_last_grant,
    output logic [NUM_CLIENTS-1:0] o_grant,
    output logic                   o_winner
);

    // Pick the sole requester, or the client not granted last when both ask.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        o_winner = 1'b0;
        o_grant  = '0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last_grant;
            default: o_winner = 1'b0;
        endcase
        if (|i_req) begin
            o_grant[o_winner] = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter: shares one start/busy/product multiplier between two
// requesters. Each accepted request latches its operands, launches one
// multiplication, captures the product and pulses done to the owner.
// Optional watchdog on the WAIT state: define MULT_ARB_WDOG_EN.
module mult32x32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [31:0]            a0,
    input  logic [31:0]            b0,
    input  logic [31:0]            a1,
    input  logic [31:0]            b1,
    output logic [NUM_CLIENTS-1:0] ack,
    output logic [NUM_CLIENTS-1:0] done,
    output logic [63:0]            product,
    output logic                   busy,
    output logic                   mult_start,
    output logic [31:0]            mult_a,
    output logic [31:0]            mult_b,
    input  logic                   mult_busy,
    input  logic [63:0]            mult_product,
    output logic                   wdog_err
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;
    logic                   r_owner;
    logic [31:0]            r_mult_a;
    logic [31:0]            r_mult_b;
    logic [63:0]            r_product;
    logic [NUM_CLIENTS-1:0] w_grant;
    logic                   w_winner;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_wdog_fire;

    rr_arb2 u_rr_arb2 (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    // A request is accepted only from IDLE; the product is taken once the
    // multiplier drops busy while we are waiting on it.
    assign w_accept = (r_state == IDLE) && (|req);
    assign w_load   = (r_state == WAIT) && !mult_busy;

    // State register plus operand, owner, history and result capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_product    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_mult_a     <= w_winner ? a1 : a0;
                r_mult_b     <= w_winner ? b1 : b0;
            end
            if (w_load) begin
                r_product <= mult_product;
            end
        end
    end

    // Next-state decode and the per-state strobes.
    always_comb begin
        w_next_state = r_state;
        ack          = '0;
        done         = '0;
        mult_start   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                ack  = w_grant;
                if (|req) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                mult_start   = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (!mult_busy) begin
                    w_next_state = DONE;
                end else if (w_wdog_fire) begin
                    w_next_state = IDLE;
                end
            end
            DONE: begin
                done[r_owner] = 1'b1;
                w_next_state  = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign product = r_product;
    assign mult_a  = r_mult_a;
    assign mult_b  = r_mult_b;

`ifdef MULT_ARB_WDOG_EN
    localparam int WDOG_CW = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_CW-1:0] r_wdog_cnt;
    logic               r_wdog_err;

    // Fires on the last allowed WAIT cycle if the multiplier is still busy.
    assign w_wdog_fire = (r_state == WAIT) && mult_busy &&
                         (r_wdog_cnt == WDOG_CW'(WDOG_CYCLES - 1));

    // WAIT-cycle counter and sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_CW'(1);
            end else begin
                r_wdog_cnt <= '0;
            end
            if (w_wdog_fire) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = (WDOG_CYCLES > 0);
    assign w_wdog_fire   = 1'b0;
    assign wdog_err      = 1'b0;
`endif

endmodule : mult32x32_arbiter

// File: tb/tb_mult32x32_arbiter.sv
// tb_mult32x32_arbiter: directed bench for the two-client multiplier arbiter,
// with a behavioural stand-in for the shared multiplier.
module tb_mult32x32_arbiter;
    import mult_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  ack, done;
    logic [63:0] product;
    logic        busy, mult_start, wdog_err;
    logic [31:0] mult_a, mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult32x32_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .ack          (ack),
        .done         (done),
        .product      (product),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .wdog_err     (wdog_err)
    );

    // Multiplier stand-in: busy from the cycle after start for 1, 2 or 4
    // work cycles depending on which operand upper halves are non-zero.
    logic        m_busy = 1'b0;
    logic        m_stuck = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_prod = '0, m_pend = '0;

    function automatic int work_cycles(input logic [31:0] a, input logic [31:0] b);
        return ((a[31:16] != 16'd0) ? 2 : 1) * ((b[31:16] != 16'd0) ? 2 : 1);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_prod <= '0;
            m_pend <= '0;
        end else if (mult_start) begin
            m_busy <= 1'b1;
            m_cnt  <= work_cycles(mult_a, mult_b);
            m_pend <= {32'd0, mult_a} * {32'd0, mult_b};
        end else if (m_busy && !m_stuck) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_prod <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    assign mult_busy    = m_busy;
    assign mult_product = m_prod;

    // Steps cycles until a done pulse appears; lat counts cycles stepped.
    task automatic wait_done(inout int lat);
        while (done === 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        total++;
        if (ack !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || mult_start !== 1'b0 || wdog_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: ack=%b done=%b busy=%b start=%b wdog=%b, want all 0", ack, done, busy, mult_start, wdog_err);
        end
        total++;
        if (product !== 64'd0 || mult_a !== 32'd0 || mult_b !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: product=%h a=%h b=%h, want 0", product, mult_a, mult_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: busy=%b ack=%b, want 0/00", busy, ack);
        end
    endtask

    // One uncontended request from client c with expected product/latency.
    task automatic test_single(input logic c, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_p, input int exp_lat, input string tag);
        int lat;
        logic [1:0] m;
        m = c ? 2'b10 : 2'b01;
        @(negedge clk);
        if (c) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
        req = m;
        #1;
        total++;
        if (ack !== m) begin
            bad++;
            $display("FAIL %s_ack: got %b want %b", tag, ack, m);
        end
        @(negedge clk);
        req = 2'b00;
        lat = 1;
        total++;
        if (mult_start !== 1'b1 || mult_a !== a || mult_b !== b || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_launch: start=%b a=%h b=%h busy=%b want 1 %h %h 1", tag, mult_start, mult_a, mult_b, busy, a, b);
        end
        wait_done(lat);
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_lat);
        end
        total++;
        if (done !== m || product !== exp_p) begin
            bad++;
            $display("FAIL %s_done: done=%b product=%h want %b %h", tag, done, product, m, exp_p);
        end
        @(negedge clk);
        total++;
        if (done !== 2'b00 || busy !== 1'b0 || mult_a !== a || mult_b !== b || product !== exp_p) begin
            bad++;
            $display("FAIL %s_after: done=%b busy=%b a=%h b=%h product=%h", tag, done, busy, mult_a, mult_b, product);
        end
    endtask

    task automatic test_contention();
        int lat;
        @(negedge clk);
        reset_n = 1'b0;
        a0 = 32'd2; b0 = 32'd4; a1 = 32'd6; b1 = 32'd8;
        req = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (ack !== 2'b01) begin
            bad++;
            $display("FAIL contend_first: ack=%b want 01", ack);
        end
        @(negedge clk);
        req = 2'b10;
        lat = 1;
        wait_done(lat);
        total++;
        if (done !== 2'b01 || product !== 64'd8 || lat != 4 || ack !== 2'b00) begin
            bad++;
            $display("FAIL contend_done0: done=%b product=%h lat=%0d ack=%b want 01 8 4 00", done, product, lat, ack);
        end
        @(negedge clk);
        total++;
        if (ack !== 2'b10 || busy !== 1'b0) begin
            bad++;
            $display("FAIL contend_second: ack=%b busy=%b want 10 0", ack, busy);
        end
        @(negedge clk);
        req = 2'b00;
        lat = 1;
        wait_done(lat);
        total++;
        if (done !== 2'b10 || product !== 64'd48 || lat != 4) begin
            bad++;
            $display("FAIL contend_done1: done=%b product=%h lat=%0d want 10 48 4", done, product, lat);
        end
        @(negedge clk);
        req = 2'b11;
        #1;
        total++;
        if (ack !== 2'b01) begin
            bad++;
            $display("FAIL contend_alternate: ack=%b want 01", ack);
        end
        @(negedge clk);
        req = 2'b10;
        lat = 1;
        wait_done(lat);
        @(negedge clk);
        total++;
        if (ack !== 2'b10) begin
            bad++;
            $display("FAIL contend_alternate1: ack=%b want 10", ack);
        end
        @(negedge clk);
        req = 2'b00;
        lat = 1;
        wait_done(lat);
        total++;
        if (done !== 2'b10 || product !== 64'd48) begin
            bad++;
            $display("FAIL contend_drain: done=%b product=%h want 10 48", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_req_in_wait();
        int lat;
        logic early_ack;
        @(negedge clk);
        a0 = 32'h0002_0000; b0 = 32'd3;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        lat = 1;
        @(negedge clk);
        lat++;
        a1 = 32'd11; b1 = 32'd13;
        req = 2'b10;
        early_ack = 1'b0;
        while (done === 2'b00 && lat < 20) begin
            #1;
            if (ack !== 2'b00) early_ack = 1'b1;
            @(negedge clk);
            lat++;
        end
        total++;
        if (early_ack !== 1'b0 || ack !== 2'b00) begin
            bad++;
            $display("FAIL wait_no_ack: early=%b ack=%b want 0 00", early_ack, ack);
        end
        total++;
        if (done !== 2'b01 || product !== 64'h0000_0000_0006_0000 || lat != 5) begin
            bad++;
            $display("FAIL wait_owner: done=%b product=%h lat=%0d want 01 60000 5", done, product, lat);
        end
        @(negedge clk);
        total++;
        if (ack !== 2'b10) begin
            bad++;
            $display("FAIL wait_next_ack: ack=%b want 10", ack);
        end
        @(negedge clk);
        req = 2'b00;
        lat = 1;
        wait_done(lat);
        total++;
        if (done !== 2'b10 || product !== 64'd143) begin
            bad++;
            $display("FAIL wait_second: done=%b product=%h want 10 143", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic seen_done;
        @(negedge clk);
        a1 = 32'h0001_0000; b1 = 32'h0001_0000;
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (busy !== 1'b0 || done !== 2'b00 || ack !== 2'b00 || mult_start !== 1'b0 || wdog_err !== 1'b0 ||
            product !== 64'd0 || mult_a !== 32'd0 || mult_b !== 32'd0) begin
            bad++;
            $display("FAIL midreset_state: busy=%b done=%b ack=%b start=%b wdog=%b product=%h a=%h b=%h",
                     busy, done, ack, mult_start, wdog_err, product, mult_a, mult_b);
        end
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 2'b00 || busy !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_quiet: activity=%b want 0", seen_done);
        end
    endtask

`ifdef MULT_ARB_WDOG_EN
    task automatic test_watchdog();
        logic bad_done;
        @(negedge clk);
        m_stuck = 1'b1;
        a0 = 32'd5; b0 = 32'd5;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        bad_done = 1'b0;
        for (int cyc = 2; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (done !== 2'b00) bad_done = 1'b1;
        end
        total++;
        if (wdog_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wdog_early: wdog=%b busy=%b want 0 1", wdog_err, busy);
        end
        @(negedge clk);
        if (done !== 2'b00) bad_done = 1'b1;
        total++;
        if (wdog_err !== 1'b1 || busy !== 1'b0 || bad_done !== 1'b0 || product !== 64'd0) begin
            bad++;
            $display("FAIL wdog_fire: wdog=%b busy=%b done_seen=%b product=%h want 1 0 0 0", wdog_err, busy, bad_done, product);
        end
        @(negedge clk);
        total++;
        if (wdog_err !== 1'b1) begin
            bad++;
            $display("FAIL wdog_sticky: wdog=%b want 1", wdog_err);
        end
        m_stuck = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (wdog_err !== 1'b0) begin
            bad++;
            $display("FAIL wdog_clear: wdog=%b want 0", wdog_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single(1'b0, 32'd3, 32'd5, 64'd15, 4, "single");
        test_single(1'b1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 7, "long");
        test_single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 7, "maxop");
        test_contention();
        test_req_in_wait();
        test_reset_mid_wait();
`ifdef MULT_ARB_WDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult32x32_arbiter
